sound_arbiter: RTL

Arbitrates the single piezo `buzz` output between background music and short game-event sound effects (bullet fire, enemy hit, stage clear). Event requesters pulse a request; the arbiter latches it, grants the buzzer to the highest-priority pending effect, and generates its square-wave tone for a fixed duration. When no effect is playing, the background-music stream passes through. It sits between the BGM generator and event sources on one side and the top-level `buzz` pin on the other, replacing the OR of `buzz_signal | fire_buzz`.

---
 rtl/sound_pkg.sv | 57 +++++
 rtl/tone_timer.sv | 77 +++++++
 rtl/sound_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sound_pkg                                              |
// | Description : Shared owner encodings, default tone/duration          |
// |               constants and small helpers for the buzzer arbiter.    |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package sound_pkg;

    // Buzzer owner encodings, ordered so a larger value is a higher priority
    localparam logic [1:0] OWN_BGM   = 2'd0;
    localparam logic [1:0] OWN_FIRE  = 2'd1;
    localparam logic [1:0] OWN_HIT   = 2'd2;
    localparam logic [1:0] OWN_CLEAR = 2'd3;

    // Defaults for a 25 MHz clock
    localparam int c_def_tick_div   = 25000;
    localparam int c_def_fire_half  = 12500;
    localparam int c_def_hit_half   = 6250;
    localparam int c_def_clear_half = 25000;
    localparam int c_def_fire_ms    = 40;
    localparam int c_def_hit_ms     = 80;
    localparam int c_def_clear_ms   = 500;

    function automatic int max3(input int a, input int b, input int c);
        int w_m;
        w_m = a;
        if (b > w_m) w_m = b;
        if (c > w_m) w_m = c;
        return w_m;
    endfunction

    // Highest-priority pending class, OWN_BGM when nothing is pending
    function automatic logic [1:0] top_class(input logic [3:1] pend);
        logic [1:0] w_cls;
        w_cls = OWN_BGM;
        if (pend[1]) w_cls = OWN_FIRE;
        if (pend[2]) w_cls = OWN_HIT;
        if (pend[3]) w_cls = OWN_CLEAR;
        return w_cls;
    endfunction

    // Pending-vector bit belonging to an effect class (none for BGM)
    function automatic logic [3:1] class_onehot(input logic [1:0] cls);
        logic [3:1] w_oh;
        w_oh = 3'b000;
        case (cls)
            OWN_FIRE:  w_oh[1] = 1'b1;
            OWN_HIT:   w_oh[2] = 1'b1;
            OWN_CLEAR: w_oh[3] = 1'b1;
            default:   w_oh = 3'b000;
        endcase
        return w_oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tone_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tone_timer                                             |
// | Description : Square-wave half-period toggle plus millisecond        |
// |               duration counter for one sound effect.                 |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tone_timer #(
    parameter int TICK_DIV = 25000,
    parameter int HALF_W   = 16,
    parameter int MS_W     = 10
) (
    input  logic              clk25,
    input  logic              reset_n,
    input  logic              load,
    input  logic              run,
    input  logic [HALF_W-1:0] half,
    input  logic [MS_W-1:0]   ms,
    output logic              tone,
    output logic              done
);

    localparam int                  c_tick_w    = $clog2(TICK_DIV) + 1;
    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);

    logic [HALF_W-1:0]   r_half_cnt;
    logic [HALF_W-1:0]   r_half_rel;
    logic                r_tone;
    logic [c_tick_w-1:0] r_tick;
    logic [MS_W-1:0]     r_ms;
    logic                w_wrap;

    assign w_wrap = (r_tick == c_tick_last);
    // Final tick of the final millisecond; a reload in the same cycle wins
    assign done   = run && !load && w_wrap && (r_ms == MS_W'(1));
    assign tone   = r_tone;

    // Half-period counter: reload and start high on load, flip tone at zero
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_half_cnt <= '0;
            r_half_rel <= '0;
            r_tone     <= 1'b0;
        end else if (load) begin
            r_half_cnt <= half - HALF_W'(1);
            r_half_rel <= half - HALF_W'(1);
            r_tone     <= 1'b1;
        end else if (run) begin
            if (r_half_cnt == '0) begin
                r_half_cnt <= r_half_rel;
                r_tone     <= ~r_tone;
            end else begin
                r_half_cnt <= r_half_cnt - HALF_W'(1);
            end
        end
    end

    // Duration: tick counter wraps every TICK_DIV cycles and consumes one ms
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_tick <= '0;
            r_ms   <= '0;
        end else if (load) begin
            r_tick <= '0;
            r_ms   <= ms;
        end else if (run) begin
            if (w_wrap) begin
                r_tick <= '0;
                r_ms   <= r_ms - MS_W'(1);
            end else begin
                r_tick <= r_tick + c_tick_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sound_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sound_arbiter                                          |
// | Description : Shares the piezo buzzer between background music and   |
// |               prioritised game-event sound effects.                  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module sound_arbiter
    import sound_pkg::*;
#(
    parameter int TICK_DIV   = c_def_tick_div,
    parameter int FIRE_HALF  = c_def_fire_half,
    parameter int HIT_HALF   = c_def_hit_half,
    parameter int CLEAR_HALF = c_def_clear_half,
    parameter int FIRE_MS    = c_def_fire_ms,
    parameter int HIT_MS     = c_def_hit_ms,
    parameter int CLEAR_MS   = c_def_clear_ms
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic       mute,
    input  logic       bgm_in,
    input  logic       fire_evt,
    input  logic       hit_evt,
    input  logic       clear_evt,
    output logic       buzz,
    output logic [1:0] owner,
    output logic       busy
);

    localparam int   c_half_w  = $clog2(max3(FIRE_HALF, HIT_HALF, CLEAR_HALF)) + 1;
    localparam int   c_ms_w    = $clog2(max3(FIRE_MS, HIT_MS, CLEAR_MS)) + 1;
    localparam logic c_st_idle = 1'b0;
    localparam logic c_st_play = 1'b1;

    logic                r_state;
    logic [1:0]          r_owner;
    logic [3:1]          r_pending;
    logic                r_buzz;

    logic [3:1]          w_evt;
    logic [3:1]          w_own_oh;
    logic [3:1]          w_grant_oh;
    logic [1:0]          w_top;
    logic [1:0]          w_load_cls;
    logic                w_grant;
    logic                w_retrig;
    logic                w_load;
    logic                w_run;
    logic                w_tone;
    logic                w_done;
    logic [c_half_w-1:0] w_half;
    logic [c_ms_w-1:0]   w_ms;

    assign w_evt      = {clear_evt, hit_evt, fire_evt};
    // Bit of the class currently playing; its events retrigger instead of latching
    assign w_own_oh   = (r_state == c_st_play) ? class_onehot(r_owner) : 3'b000;
    assign w_top      = top_class(r_pending);
    // Grant from IDLE, or preempt when something strictly higher is waiting
    assign w_grant    = (w_top != OWN_BGM) && ((r_state == c_st_idle) || (w_top > r_owner));
    assign w_grant_oh = w_grant ? class_onehot(w_top) : 3'b000;
    assign w_retrig   = |(w_evt & w_own_oh);
    assign w_load     = !mute && (w_grant || w_retrig);
    assign w_run      = !mute && (r_state == c_st_play);
    assign w_load_cls = w_grant ? w_top : r_owner;

    // Tone half-period and duration for the class being (re)loaded
    always_comb begin
        w_half = c_half_w'(FIRE_HALF);
        w_ms   = c_ms_w'(FIRE_MS);
        case (w_load_cls)
            OWN_HIT: begin
                w_half = c_half_w'(HIT_HALF);
                w_ms   = c_ms_w'(HIT_MS);
            end
            OWN_CLEAR: begin
                w_half = c_half_w'(CLEAR_HALF);
                w_ms   = c_ms_w'(CLEAR_MS);
            end
            default: begin
                w_half = c_half_w'(FIRE_HALF);
                w_ms   = c_ms_w'(FIRE_MS);
            end
        endcase
    end

    tone_timer #(
        .TICK_DIV (TICK_DIV),
        .HALF_W   (c_half_w),
        .MS_W     (c_ms_w)
    ) u_tone_timer (
        .clk25   (clk25),
        .reset_n (reset_n),
        .load    (w_load),
        .run     (w_run),
        .half    (w_half),
        .ms      (w_ms),
        .tone    (w_tone),
        .done    (w_done)
    );

    // Request latch: new events set bits, a grant clears its bit, mute flushes
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 3'b000;
        end else if (mute) begin
            r_pending <= 3'b000;
        end else begin
            r_pending <= (r_pending & ~w_grant_oh) | (w_evt & ~w_own_oh);
        end
    end

    // Arbiter FSM: IDLE passes BGM, PLAY owns the buzzer until done or preempted
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
            r_owner <= OWN_BGM;
        end else if (mute) begin
            r_state <= c_st_idle;
            r_owner <= OWN_BGM;
        end else if (w_grant) begin
            r_state <= c_st_play;
            r_owner <= w_top;
        end else if (w_done) begin
            r_state <= c_st_idle;
            r_owner <= OWN_BGM;
        end
    end

    // Registered buzzer drive
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_buzz <= 1'b0;
        end else if (mute) begin
            r_buzz <= 1'b0;
        end else if (r_state == c_st_play) begin
            r_buzz <= w_tone;
        end else begin
            r_buzz <= bgm_in;
        end
    end

    assign buzz  = r_buzz;
    assign owner = r_owner;
    assign busy  = (r_state == c_st_play);

endmodule
`default_nettype wire
